reg_file_param: RTL

//   Parametrised processor register file: one write port, two registered read ports (A, B).

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/rf_clear_seq.sv | 60 ++++++
 rtl/reg_file_param.sv | 83 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parametrised register file.
package reg_file_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 4;

  typedef enum logic [0:0] {
    IDLE,
    SWEEP
  } clr_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every word address once after a Clr pulse, holding busy
// for exactly DEPTH cycles.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          // Terminal count exits the sweep, so the counter never wraps.
          if (cnt_q == LastAddr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Register file: one write port, two registered read ports, optional write-first bypass,
// optional hard-wired zero word 0, and a multi-cycle clear sweep.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Wen,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [DATA_W-1:0] WData,
  input  logic [ADDR_W-1:0] RAAddr,
  input  logic [ADDR_W-1:0] RBAddr,
  input  logic              RAen,
  input  logic              RBen,
  input  logic              Clr,
  output logic [DATA_W-1:0] RAData,
  output logic [DATA_W-1:0] RBData,
  output logic              Busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ra_q, rb_q;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk     (Clk),
    .rst     (Rst),
    .clr     (Clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign wr_ok = Wen && !busy && !(ZERO_R0 && (WAddr == '0));

  always_comb begin
    rd_a = mem_q[RAAddr];
    rd_b = mem_q[RBAddr];
    if (BYPASS && wr_ok && (WAddr == RAAddr)) rd_a = WData;
    if (BYPASS && wr_ok && (WAddr == RBAddr)) rd_b = WData;
    // The zero word wins over any forwarded write data.
    if (ZERO_R0 && (RAAddr == '0)) rd_a = '0;
    if (ZERO_R0 && (RBAddr == '0)) rd_b = '0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[WAddr] <= WData;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ra_q <= '0;
      rb_q <= '0;
    end else if (!busy) begin
      if (RAen) ra_q <= rd_a;
      if (RBen) rb_q <= rd_b;
    end
  end

  assign RAData = ra_q;
  assign RBData = rb_q;
  assign Busy   = busy;

endmodule
